ysyx_22050039_ifu: RTL and testbench
====================================

YSYX_22050039_IFU -- requirements
Module: ysyx_22050039_ifu

Interface
REQ-001 Parameter XLEN SHALL default to 64 and set the address and PC width.
REQ-002 Parameter INST_LEN SHALL default to 32 and set the instruction width.
REQ-003 Parameter RESET_PC SHALL default to 64'h8000_0000 and set the first fetch address.
REQ-004 clk  in  1: the single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1: reset SHALL be asynchronous and active-low (0 = reset asserted).
REQ-006 mem_req_valid  out  1: fetch request valid.
REQ-007 mem_req_ready  in  1: memory accepts the request.
REQ-008 mem_req_addr  out  XLEN: fetch address, always equal to pc.
REQ-009 mem_rsp_valid  in  1: response data valid.
REQ-010 mem_rsp_data  in  INST_LEN: fetched instruction word.
REQ-011 mem_rsp_err  in  1: access error, qualified by mem_rsp_valid.
REQ-012 inst_valid  out  1: instruction offered to the decoder.
REQ-013 inst_ready  in  1: decoder/execute consumes the instruction this cycle.
REQ-014 inst  out  INST_LEN: registered instruction word.
REQ-015 pc  out  XLEN: address of inst.
REQ-016 pc_wen  in  1: redirect request, sampled only on the inst handshake cycle.
REQ-017 dnpc  in  XLEN: redirect target, qualified by pc_wen.
REQ-018 fetch_fault  out  1: sticky fault flag.

Function
REQ-019 FSM states SHALL be REQ, WAIT, HOLD and FAULT.
REQ-020 REQ: mem_req_valid=1; on mem_req_ready=1 the FSM SHALL go to WAIT.
REQ-021 WAIT: on mem_rsp_valid=1 with err=0 the FSM SHALL latch mem_rsp_data into inst and go to HOLD; on err=1 it SHALL go to FAULT.
REQ-022 HOLD: inst_valid=1; inst and pc SHALL be stable until inst_valid & inst_ready.
REQ-023 On the HOLD handshake: pc <= pc_wen ? dnpc : pc+4 (mod 2^XLEN, wrap permitted), and the FSM SHALL go to REQ.
REQ-024 On the HOLD handshake, if pc_wen=1 and dnpc[1:0]!=0, then pc SHALL still load dnpc and the FSM SHALL go to FAULT.
REQ-025 FAULT: no request and inst_valid=0; fetch_fault=1 until reset.
REQ-026 mem_rsp_valid outside WAIT SHALL be ignored (stale response after reset).
REQ-027 pc_wen outside the handshake cycle SHALL be ignored.
REQ-028 Minimum latency SHALL be 3 cycles per instruction (REQ, WAIT, HOLD), with zero-wait memory and inst_ready held at 1.
REQ-029 mem_req_valid, inst_valid and fetch_fault SHALL be decoded from registered state only, with no combinational input-to-output path.

Reset
REQ-030 While rst=0 the block SHALL hold state=REQ, pc=RESET_PC, inst=0 and fetch_fault=0.
REQ-031 While rst=0, mem_req_valid and inst_valid SHALL be 0, and mem_req_valid SHALL be 1 from the first edge after release.
REQ-032 Reset asserted in any state, including mid-WAIT, SHALL abort the transaction and return to REQ at RESET_PC.

Configuration
REQ-033 With YSYX_22050039_IFU_PERF_EN defined, the block SHALL add output fetch_cnt[63:0] (inst handshakes) and output stall_cnt[63:0] (cycles spent in WAIT).
REQ-034 Both counters SHALL reset to 0 and saturate at all-ones.
REQ-035 With YSYX_22050039_IFU_PERF_EN undefined, the counter ports and logic SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-036 Package ysyx_22050039_pkg SHALL hold the FSM state enum, RESET_PC default and INST_LEN.
REQ-037 The PC SHALL live in sub-module ysyx_22050039_pc_reg (async active-low reset to RESET_PC, load enable, XLEN-wide).

Verification
REQ-038 Release reset, ready=1, rsp one cycle later with data 0x00000513 -> req_addr 0x80000000; inst_valid=1 with inst=0x00000513 on the 3rd cycle; next req_addr 0x80000004.
REQ-039 Hold inst_ready=0 for 5 cycles in HOLD -> inst/pc stable and no new request; on ready=1, pc=0x80000004.
REQ-040 Handshake with pc_wen=1, dnpc=0x80000100 -> next req_addr 0x80000100; pc_wen=1 pulsed in WAIT -> ignored.
REQ-041 dnpc=0x80000102 on handshake -> FAULT, fetch_fault=1, no req; mem_rsp_err=1 in WAIT -> FAULT.
REQ-042 Assert rst mid-WAIT, then deliver the stale rsp after release -> rsp ignored, req_addr=0x80000000.
REQ-043 With PERF_EN, 10 instructions at 2 wait cycles each -> fetch_cnt=10, stall_cnt=30.

Source files
------------

// File: rtl/ysyx_22050039_pkg.sv
// Shared types and defaults for the ysyx_22050039 instruction fetch unit.
// Optional feature macro: YSYX_22050039_IFU_PERF_EN (performance counters).
package ysyx_22050039_pkg;

  localparam int          DEFAULT_INST_LEN = 32;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

  // Fetch FSM: issue request, wait for response, hold for decoder, dead on fault
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } ifu_state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [63:0] sat_inc64(input logic [63:0] val);
    return (&val) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/ysyx_22050039_ifu_if.sv
// Bundle of the IFU memory-side and decoder-side handshake signals.
// master = the fetch unit, slave = memory plus decoder environment.
interface ysyx_22050039_ifu_if #(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32
);

  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [XLEN-1:0]     mem_req_addr;
  logic                mem_rsp_valid;
  logic [INST_LEN-1:0] mem_rsp_data;
  logic                mem_rsp_err;
  logic                inst_valid;
  logic                inst_ready;
  logic [INST_LEN-1:0] inst;
  logic [XLEN-1:0]     pc;
  logic                pc_wen;
  logic [XLEN-1:0]     dnpc;
  logic                fetch_fault;

  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst, pc, fetch_fault,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
           inst_ready, pc_wen, dnpc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst, pc, fetch_fault,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
           inst_ready, pc_wen, dnpc
  );

endinterface

// File: rtl/ysyx_22050039_pc_reg.sv
// Program counter register: async active-low reset to RESET_PC, load enable.
module ysyx_22050039_pc_reg #(
  parameter int          XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] pc
);

  // PC holds its value unless the fetch unit commits a new one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= XLEN'(RESET_PC);
    end else if (load_en) begin
      pc <= load_val;
    end
  end

endmodule

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: one outstanding request, instruction held in a
// register until the decoder takes it, sticky fault on error/misalignment.
// Optional feature macro: YSYX_22050039_IFU_PERF_EN adds fetch_cnt/stall_cnt.
module ysyx_22050039_ifu
  import ysyx_22050039_pkg::*;
#(
  parameter int          XLEN     = 64,
  parameter int          INST_LEN = DEFAULT_INST_LEN,
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_22050039_ifu_if.master         bus
`ifdef YSYX_22050039_IFU_PERF_EN
  ,
  output logic [63:0]                 fetch_cnt,
  output logic [63:0]                 stall_cnt
`endif
);

  ifu_state_e          state;
  logic                req_valid_q;
  logic                inst_valid_q;
  logic                fault_q;
  logic [INST_LEN-1:0] inst_q;
  logic [XLEN-1:0]     pc_q;
  logic [XLEN-1:0]     pc_next;
  logic                handshake;
  logic                redirect_bad;

  // Decoder consumes the held instruction; pc_wen/dnpc only matter here
  assign handshake    = inst_valid_q & bus.inst_ready;
  assign redirect_bad = bus.pc_wen & (bus.dnpc[1:0] != 2'b00);
  assign pc_next      = bus.pc_wen ? bus.dnpc : pc_q + XLEN'(4);

  ysyx_22050039_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load_en  (handshake),
    .load_val (pc_next),
    .pc       (pc_q)
  );

  // Fetch FSM with registered outputs. req_valid_q is cleared by reset and
  // rises on the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_REQ;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      inst_q       <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          if (req_valid_q && bus.mem_req_ready) begin
            state       <= ST_WAIT;
            req_valid_q <= 1'b0;
          end else begin
            req_valid_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.mem_rsp_valid) begin
            if (bus.mem_rsp_err) begin
              state   <= ST_FAULT;
              fault_q <= 1'b1;
            end else begin
              state        <= ST_HOLD;
              inst_valid_q <= 1'b1;
              inst_q       <= bus.mem_rsp_data;
            end
          end
        end
        ST_HOLD: begin
          if (bus.inst_ready) begin
            inst_valid_q <= 1'b0;
            if (redirect_bad) begin
              state   <= ST_FAULT;
              fault_q <= 1'b1;
            end else begin
              state       <= ST_REQ;
              req_valid_q <= 1'b1;
            end
          end
        end
        ST_FAULT: begin
          // Only reset leaves the fault state
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
          fault_q      <= 1'b1;
        end
        default: begin
          state        <= ST_REQ;
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
          fault_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = pc_q;
  assign bus.inst_valid    = inst_valid_q;
  assign bus.inst          = inst_q;
  assign bus.pc            = pc_q;
  assign bus.fetch_fault   = fault_q;

`ifdef YSYX_22050039_IFU_PERF_EN
  // Saturating counters: consumed instructions and cycles spent in WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (handshake) begin
        fetch_cnt <= sat_inc64(fetch_cnt);
      end
      if (state == ST_WAIT) begin
        stall_cnt <= sat_inc64(stall_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// Directed bench for ysyx_22050039_ifu: table of fetch transactions plus
// hand-written sequences for fault, reset and counter corner cases.
module tb_ysyx_22050039_ifu;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  ysyx_22050039_ifu_if #(.XLEN(64), .INST_LEN(32)) bus ();

`ifdef YSYX_22050039_IFU_PERF_EN
  logic [63:0] fetch_cnt;
  logic [63:0] stall_cnt;
`endif

  ysyx_22050039_ifu #(
    .XLEN     (64),
    .INST_LEN (32),
    .RESET_PC (64'h8000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef YSYX_22050039_IFU_PERF_EN
    ,
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          waits;
    int          stall;
    logic        wen;
    logic [63:0] dnpc;
    logic [63:0] exp_pc;
    logic [63:0] exp_next;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.mem_rsp_err   = 1'b0;
    bus.inst_ready    = 1'b0;
    bus.pc_wen        = 1'b0;
    bus.dnpc          = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Wait (bounded) for a request, check its address, accept it -> WAIT
  task automatic issue_req(input logic [63:0] exp_addr);
    int n;
    n = 0;
    while (!bus.mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    check("req_valid", 64'(bus.mem_req_valid), 64'd1);
    check("req_addr", bus.mem_req_addr, exp_addr);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
  endtask

  // Full fetch up to HOLD; pc_wen pulsed in WAIT must be ignored
  task automatic run_to_hold(input logic [63:0] exp_pc, input logic [31:0] data, input int waits);
    issue_req(exp_pc);
    bus.pc_wen = 1'b1;
    bus.dnpc   = 64'h0000_0000_dead_beef;
    for (int k = 0; k < waits; k++) begin
      tick();
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = data;
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.pc_wen        = 1'b0;
    bus.dnpc          = '0;
    check("hold_inst_valid", 64'(bus.inst_valid), 64'd1);
    check("hold_inst", 64'(bus.inst), 64'(data));
    check("hold_pc", bus.pc, exp_pc);
  endtask

  task automatic handshake(input logic wen, input logic [63:0] dnpc);
    bus.inst_ready = 1'b1;
    bus.pc_wen     = wen;
    bus.dnpc       = dnpc;
    tick();
    bus.inst_ready = 1'b0;
    bus.pc_wen     = 1'b0;
    bus.dnpc       = '0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{32'h0000_0513, 0, 5, 1'b0, 64'h0,           64'h8000_0000, 64'h8000_0004};
    vecs[1] = '{32'h0010_0593, 1, 0, 1'b1, 64'h8000_0100, 64'h8000_0004, 64'h8000_0100};
    vecs[2] = '{32'hfff0_0613, 2, 1, 1'b0, 64'h0,           64'h8000_0100, 64'h8000_0104};
    vecs[3] = '{32'h0000_8067, 0, 0, 1'b1, 64'h8000_0000, 64'h8000_0104, 64'h8000_0000};
    vecs[4] = '{32'h1234_5678, 0, 2, 1'b0, 64'h0,           64'h8000_0000, 64'h8000_0004};

    // Reset state
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    check("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("rst_fault", 64'(bus.fetch_fault), 64'd0);
    check("rst_pc", bus.pc, 64'h8000_0000);
    check("rst_inst", 64'(bus.inst), 64'd0);
    rst = 1'b1;
    #1;
    check("release_req_valid", 64'(bus.mem_req_valid), 64'd0);
    tick();
    check("first_edge_req_valid", 64'(bus.mem_req_valid), 64'd1);

    // Table-driven fetch transactions
    for (int i = 0; i < 5; i++) begin
      run_to_hold(vecs[i].exp_pc, vecs[i].data, vecs[i].waits);
      for (int s = 0; s < vecs[i].stall; s++) begin
        bus.pc_wen = 1'b1;
        bus.dnpc   = 64'h0000_0000_8000_0200;
        tick();
        check("stall_inst_valid", 64'(bus.inst_valid), 64'd1);
        check("stall_inst", 64'(bus.inst), 64'(vecs[i].data));
        check("stall_pc", bus.pc, vecs[i].exp_pc);
        check("stall_no_req", 64'(bus.mem_req_valid), 64'd0);
      end
      handshake(vecs[i].wen, vecs[i].dnpc);
      check("next_req_valid", 64'(bus.mem_req_valid), 64'd1);
      check("next_req_addr", bus.mem_req_addr, vecs[i].exp_next);
      check("next_inst_valid", 64'(bus.inst_valid), 64'd0);
    end

    // Misaligned redirect: pc still loads dnpc, then sticky fault
    run_to_hold(64'h8000_0004, 32'h0000_0013, 0);
    handshake(1'b1, 64'h8000_0102);
    check("mis_fault", 64'(bus.fetch_fault), 64'd1);
    check("mis_no_req", 64'(bus.mem_req_valid), 64'd0);
    check("mis_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("mis_pc", bus.pc, 64'h8000_0102);
    bus.mem_req_ready = 1'b1;
    bus.inst_ready    = 1'b1;
    tick();
    tick();
    tick();
    check("mis_fault_sticky", 64'(bus.fetch_fault), 64'd1);
    check("mis_still_no_req", 64'(bus.mem_req_valid), 64'd0);

    // Response error in WAIT -> fault
    do_reset();
    check("err_fault_cleared", 64'(bus.fetch_fault), 64'd0);
    issue_req(64'h8000_0000);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_err   = 1'b1;
    bus.mem_rsp_data  = 32'h0000_0513;
    tick();
    clear_inputs();
    check("err_fault", 64'(bus.fetch_fault), 64'd1);
    check("err_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("err_no_req", 64'(bus.mem_req_valid), 64'd0);

    // Reset mid-WAIT, stale response delivered after release
    do_reset();
    run_to_hold(64'h8000_0000, 32'h0000_0513, 0);
    handshake(1'b0, 64'h0);
    issue_req(64'h8000_0004);
    rst = 1'b0;
    #1;
    check("async_rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("async_rst_pc", bus.pc, 64'h8000_0000);
    @(posedge clk);
    #1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0bad_0bad;
    rst = 1'b1;
    tick();
    check("stale_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("stale_req_valid", 64'(bus.mem_req_valid), 64'd1);
    check("stale_req_addr", bus.mem_req_addr, 64'h8000_0000);
    tick();
    bus.mem_rsp_valid = 1'b0;
    check("stale_inst", 64'(bus.inst), 64'd0);
    run_to_hold(64'h8000_0000, 32'h0000_0413, 1);
    handshake(1'b0, 64'h0);

`ifdef YSYX_22050039_IFU_PERF_EN
    // Ten instructions with two empty WAIT cycles each
    do_reset();
    check("cnt_fetch_rst", fetch_cnt, 64'd0);
    check("cnt_stall_rst", stall_cnt, 64'd0);
    for (int i = 0; i < 10; i++) begin
      run_to_hold(64'h8000_0000 + 64'(4 * i), 32'h0000_0013, 2);
      handshake(1'b0, 64'h0);
    end
    check("cnt_fetch", fetch_cnt, 64'd10);
    check("cnt_stall", stall_cnt, 64'd30);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
